// File: rtl/arm_fetch.sv
// arm_fetch: instruction fetch stage feeding decode. Owns the fetch PC and keeps at most
// one word request outstanding. Returned words are buffered with their PCs in an in-order queue.
module arm_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] fetch_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      tag_pc_q, tag_pc_d;
  logic             discard_q, discard_d;

  logic [31:0]      q_pc   [FIFO_DEPTH];
  logic [31:0]      q_data [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             has_space, accept, push, pop, flush;

  assign imem_req_addr = fetch_pc_q;
  assign fetch_pc      = fetch_pc_q;
  assign inst          = q_data[rd_ptr_q];
  assign inst_pc       = q_pc[rd_ptr_q];

  always_comb begin
    // NOTE: every signal driven here is defaulted first, so no path can infer a latch.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    discard_d  = discard_q;
    push       = 1'b0;
    flush      = 1'b0;

    // Space is judged before any same-cycle pop, so a push can never find the queue full.
    has_space      = count_q < DEPTH_CNT;
    imem_req_valid = (state_q == S_REQ) && has_space && !halt && !rst;
    accept         = imem_req_valid && imem_req_ready;
    inst_valid     = (count_q != '0) && (state_q != S_HALT);

    case (state_q)
      S_REQ: begin
        if (accept) begin
          tag_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          push      = !discard_q;
          discard_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      default: ;
    endcase

    if (state_q != S_HALT) begin
      if (halt) begin
        state_d = S_HALT;
        push    = 1'b0;
      end else if (redirect_valid) begin
        fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
        flush      = 1'b1;
        push       = 1'b0;
        // A request accepted this cycle, or one still in flight, is wrong-path work.
        if (state_q == S_REQ) discard_d = accept;
        else                  discard_d = !imem_resp_valid;
      end
    end

    pop = inst_valid && inst_ready && !flush;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tag_pc_q   <= tag_pc_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: queue storage is reset because inst/inst_pc read it directly and must be 0 out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_data[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr_q]   <= tag_pc_q;
        q_data[wr_ptr_q] <= imem_resp_data;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_arm_fetch.sv
// Self-checking bench for arm_fetch: a hand-computed vector table, directed corner
// sequences and randomized traffic compared against a transaction-level reference model.
module tb_arm_fetch;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] fetch_pc;

  arm_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  typedef struct {
    logic        ir;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
    logic [31:0] fpc;
  } vec_t;

  // Reference model: fetch pointer, one in-flight request and the decode-visible queue.
  entry_t      mq[$];
  logic [31:0] m_pc, m_opc;
  logic        m_out, m_wrong, m_halted;
  logic        e_req_valid, e_inst_valid;

  // Memory environment.
  logic        mem_pending;
  logic [31:0] mem_addr;
  int          mem_delay, mem_lat;
  logic        rand_lat;

  logic        s_acc, s_cons;
  logic [31:0] s_acc_addr, s_cons_pc;
  logic [31:0] acc_log[$];
  logic [31:0] cons_log[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] acc_at(input int idx);
    return (acc_log.size() > idx) ? acc_log[idx] : 32'hEEEE_EEEE;
  endfunction

  function automatic logic [31:0] cons_at(input int idx);
    return (cons_log.size() > idx) ? cons_log[idx] : 32'hEEEE_EEEE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc     = RST_PC;
    m_opc    = '0;
    m_out    = 1'b0;
    m_wrong  = 1'b0;
    m_halted = 1'b0;
  endtask

  task automatic tick_pre();
    imem_resp_valid = mem_pending && (mem_delay == 0);
    imem_resp_data  = imem_resp_valid ? word_of(mem_addr) : 32'hDEAD_BEEF;
    #2;
    e_req_valid  = !rst && !m_halted && !m_out && (mq.size() < DEPTH) && !halt;
    e_inst_valid = !m_halted && (mq.size() > 0);
    s_acc        = imem_req_valid && imem_req_ready;
    s_acc_addr   = imem_req_addr;
    s_cons       = inst_valid && inst_ready && !redirect_valid && !halt;
    s_cons_pc    = inst_pc;
    check_bit("req_valid", imem_req_valid, e_req_valid);
    if (!rst) begin
      check("req_addr", imem_req_addr, m_pc);
      check("fetch_pc", fetch_pc, m_pc);
      check_bit("inst_valid", inst_valid, e_inst_valid);
      if (e_inst_valid) begin
        check("inst_pc", inst_pc, mq[0].pc);
        check("inst", inst, mq[0].data);
      end
    end
  endtask

  task automatic tick_post();
    logic   acc, pop, resp;
    entry_t e;
    acc  = e_req_valid && imem_req_ready;
    pop  = e_inst_valid && inst_ready;
    resp = m_out && imem_resp_valid;
    @(posedge clk);
    if (rst) begin
      model_reset();
      mem_pending = 1'b0;
    end else begin
      if (!m_halted) begin
        if (halt) begin
          m_halted = 1'b1;
        end else if (redirect_valid) begin
          mq.delete();
          m_pc = redirect_pc & 32'hFFFF_FFFC;
          if (acc) begin
            m_out = 1'b1; m_wrong = 1'b1;
          end else if (resp) begin
            m_out = 1'b0; m_wrong = 1'b0;
          end else if (m_out) begin
            m_wrong = 1'b1;
          end
        end else begin
          if (pop) void'(mq.pop_front());
          if (resp) begin
            if (!m_wrong) begin
              e.pc = m_opc; e.data = word_of(m_opc);
              mq.push_back(e);
            end
            m_out = 1'b0; m_wrong = 1'b0;
          end
          if (acc) begin
            m_opc = m_pc; m_pc = m_pc + 32'd4; m_out = 1'b1;
          end
        end
      end
      if (imem_resp_valid) mem_pending = 1'b0;
      else if (mem_pending && mem_delay > 0) mem_delay--;
      if (s_acc) begin
        mem_pending = 1'b1;
        mem_addr    = s_acc_addr;
        mem_delay   = (rand_lat ? int'($urandom_range(1, 3)) : mem_lat) - 1;
        acc_log.push_back(s_acc_addr);
      end
      if (s_cons) cons_log.push_back(s_cons_pc);
    end
    #1;
  endtask

  task automatic tick();
    tick_pre();
    tick_post();
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    inst_ready = 1'b0; imem_req_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_bit("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_fetch_pc", fetch_pc, RST_PC);
    acc_log.delete();
    cons_log.delete();
  endtask

  task automatic run_until_acc(input logic [31:0] addr, input int bound, input string name);
    logic found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      tick();
      if (s_acc && s_acc_addr == addr) found = 1'b1;
    end
    check_bit(name, found, 1'b1);
  endtask

  task automatic run_until_cons(input int n, input int bound, input string name);
    for (int i = 0; i < bound && cons_log.size() < n; i++) tick();
    check_bit(name, cons_log.size() >= n, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   reqs;

    vecs[0] = '{ir: 1'b1, rv: 1'b1, addr: 32'h0, iv: 1'b0, ipc: 32'h0, fpc: 32'h0};
    vecs[1] = '{ir: 1'b1, rv: 1'b0, addr: 32'h4, iv: 1'b0, ipc: 32'h0, fpc: 32'h4};
    vecs[2] = '{ir: 1'b1, rv: 1'b1, addr: 32'h4, iv: 1'b1, ipc: 32'h0, fpc: 32'h4};
    vecs[3] = '{ir: 1'b1, rv: 1'b0, addr: 32'h8, iv: 1'b0, ipc: 32'h0, fpc: 32'h8};
    vecs[4] = '{ir: 1'b1, rv: 1'b1, addr: 32'h8, iv: 1'b1, ipc: 32'h4, fpc: 32'h8};
    vecs[5] = '{ir: 1'b1, rv: 1'b0, addr: 32'hC, iv: 1'b0, ipc: 32'h0, fpc: 32'hC};
    vecs[6] = '{ir: 1'b1, rv: 1'b1, addr: 32'hC, iv: 1'b1, ipc: 32'h8, fpc: 32'hC};

    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    mem_pending = 1'b0; mem_addr = '0; mem_delay = 0; mem_lat = 1; rand_lat = 1'b0;
    model_reset();
    #1;

    // Steady-state fetch with 1-cycle memory: one instruction every two cycles.
    do_reset();
    imem_req_ready = 1'b1;
    for (int r = 0; r < 7; r++) begin
      inst_ready = vecs[r].ir;
      tick_pre();
      check_bit($sformatf("vec%0d_req_valid", r), imem_req_valid, vecs[r].rv);
      check($sformatf("vec%0d_req_addr", r), imem_req_addr, vecs[r].addr);
      check($sformatf("vec%0d_fetch_pc", r), fetch_pc, vecs[r].fpc);
      check_bit($sformatf("vec%0d_inst_valid", r), inst_valid, vecs[r].iv);
      if (vecs[r].iv) begin
        check($sformatf("vec%0d_inst_pc", r), inst_pc, vecs[r].ipc);
        check($sformatf("vec%0d_inst", r), inst, word_of(vecs[r].ipc));
      end
      tick_post();
    end

    // Back-pressure: queue fills to two entries and requests stop.
    do_reset();
    imem_req_ready = 1'b1; mem_lat = 1;
    for (int i = 0; i < 10; i++) tick();
    tick_pre();
    check_bit("bp_req_valid", imem_req_valid, 1'b0);
    check_bit("bp_inst_valid", inst_valid, 1'b1);
    check("bp_inst_pc", inst_pc, 32'h0);
    check("bp_fetch_pc", fetch_pc, 32'h8);
    tick_post();
    acc_log.delete(); cons_log.delete();
    inst_ready = 1'b1;
    run_until_cons(2, 20, "bp_drain_timeout");
    for (int i = 0; i < 4; i++) tick();
    check("bp_drain0", cons_at(0), 32'h0);
    check("bp_drain1", cons_at(1), 32'h4);
    check("bp_resume_addr", acc_at(0), 32'h8);

    // Redirect while the request to 0x8 is still in flight.
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 3;
    run_until_acc(32'h8, 40, "redir_wait_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    acc_log.delete(); cons_log.delete();
    run_until_cons(2, 60, "redir_cons_timeout");
    check("redir_next_addr", acc_at(0), 32'h100);
    check("redir_first_pc", cons_at(0), 32'h100);
    check("redir_second_pc", cons_at(1), 32'h104);

    // Redirect in the same cycle as the WAIT response.
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 1;
    run_until_acc(32'h4, 20, "redir_resp_wait_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    acc_log.delete(); cons_log.delete();
    run_until_cons(1, 20, "redir_resp_cons_timeout");
    check("redir_resp_next_addr", acc_at(0), 32'h200);
    check("redir_resp_first_pc", cons_at(0), 32'h200);

    // Fetch address wraps from the top of the address space.
    do_reset();
    inst_ready = 1'b1; mem_lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    acc_log.delete(); cons_log.delete();
    tick();
    check("wrap_req_addr", acc_at(0), 32'hFFFF_FFFC);
    check("wrap_fetch_pc", fetch_pc, 32'h0);
    run_until_cons(1, 20, "wrap_cons_timeout");
    check("wrap_inst_pc", cons_at(0), 32'hFFFF_FFFC);

    // Halt with one entry queued and a request outstanding.
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b0; mem_lat = 2;
    run_until_acc(32'h4, 20, "halt_setup_timeout");
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick_pre();
    check_bit("halt_inst_valid", inst_valid, 1'b0);
    tick_post();
    reqs = 0;
    inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      redirect_valid = (i == 5);
      redirect_pc    = 32'h300;
      tick_pre();
      if (imem_req_valid) reqs++;
      tick_post();
    end
    redirect_valid = 1'b0;
    check("halt_no_requests", reqs, 0);
    check("halt_fetch_pc", fetch_pc, 32'h8);
    do_reset();
    imem_req_ready = 1'b1;
    tick_pre();
    check_bit("halt_reset_req_valid", imem_req_valid, 1'b1);
    check("halt_reset_req_addr", imem_req_addr, RST_PC);
    tick_post();

    // Randomized traffic against the reference model.
    rand_lat = 1'b1;
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      for (int i = 0; i < 600; i++) begin
        imem_req_ready = ($urandom_range(0, 3) != 0);
        inst_ready     = ($urandom_range(0, 2) != 0);
        redirect_valid = ($urandom_range(0, 19) == 0);
        redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : 32'($urandom);
        halt           = (ep == 3 && i > 400) ? ($urandom_range(0, 49) == 0) : 1'b0;
        tick();
      end
    end

    rst = 1'b0; halt = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0; imem_req_ready = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/arm_fetch.md
Name: arm_fetch

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready handshake.
- Buffers returned words with their PCs in a small in-order queue and presents them to decode as inst/inst_pc with a valid/ready handshake.
- Accepts PC redirects (branch pc_we/pc_in) and halt from decode; a redirect flushes wrong-path work.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, instruction queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  response word valid.
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  inst/inst_pc valid to decode.
- inst_ready  in  1  decode consumes head entry this cycle.
- inst  out  32  instruction to decode.
- inst_pc  out  32  address of inst.
- redirect_valid  in  1  PC write from decode (pc_we).
- redirect_pc  in  32  new PC (pc_in).
- halt  in  1  stop fetching (SWI decoded).
- fetch_pc  out  32  current next-fetch address (debug/trace).

Behaviour:
- Reset is synchronous, active-high; only clk is used.
- Reset values: imem_req_valid=0, imem_req_addr=fetch_pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, queue empty, discard=0, state REQ.
- States:
  - REQ: request may be issued.
  - WAIT: exactly one request outstanding.
  - HALT: terminal.
- Memory contract:
  - Responses return in order, at most one outstanding.
  - Response arrives ≥1 cycle after request acceptance.
- REQ:
  - imem_req_valid=1 iff queue count < FIFO_DEPTH and halt=0; addr=fetch_pc.
  - Occupancy is evaluated before any same-cycle pop (conservative).
  - On valid&ready: fetch_pc+=4 (mod 2^32, so 0xFFFF_FFFC wraps to 0); tag the outstanding PC; go WAIT.
  - imem_req_valid and addr hold stable until accepted unless a redirect occurs.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid: if discard=0, push {tag PC, data}; if discard=1, drop the word and clear discard; go REQ.
- Redirect (highest priority, any state except HALT):
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - Queue flushed; inst_valid=0 next cycle.
  - A same-cycle pop is ignored.
- Redirect vs. outstanding work:
  - In WAIT without a same-cycle response: set discard=1, stay WAIT.
  - In WAIT with a same-cycle response: the response is dropped, discard stays 0, go REQ.
  - In REQ with a same-cycle request acceptance: the old-address request counts as outstanding; go WAIT with discard=1.
- Queue:
  - inst_valid = !empty && state!=HALT; inst/inst_pc are the head entry, combinationally from storage.
  - Pop on inst_valid&inst_ready.
  - Push and pop in the same cycle are both honoured.
  - Push never overflows, because space is reserved at request time.
- Halt:
  - On halt=1 (sampled at edge) go HALT: no new requests; inst_valid forced 0; redirects ignored.
  - An outstanding response is still accepted from memory and dropped.
  - Only rst leaves HALT.
  - halt and redirect in the same cycle: halt wins.
- Latency:
  - Request accepted at cycle N, response at N+k, head of an empty queue: inst_valid at N+k+1.
  - Steady state with k=1 and inst_ready=1: one instruction every 2 cycles.

Test Plan:
- Reset then memory ready with 1-cycle latency, inst_ready=1: requests to 0x0,0x4,0x8; decode sees inst_pc 0x0,0x4,0x8 with matching data in order; fetch_pc=0xC after the third acceptance.
- inst_ready=0 for 10 cycles: queue fills to 2 entries; imem_req_valid stays 0; entries 0x0,0x4 held stable; release drains in order and fetching resumes at 0x8.
- redirect_valid=1, redirect_pc=0x103 while a request to 0x8 is outstanding: 0x8 response dropped; next request addr=0x100; first inst_pc after the redirect=0x100; flushed entries never appear.
- Redirect in the same cycle as a WAIT response: that response is not queued; next request goes to redirect_pc with no extra dropped response.
- fetch_pc=0xFFFF_FFFC: request accepted, fetch_pc becomes 0x0000_0000, inst_pc=0xFFFF_FFFC.
- halt=1 with a request outstanding and 1 queued entry: inst_valid drops next cycle; response absorbed; imem_req_valid stays 0 for 20 cycles; a later redirect has no effect; rst restores the RESET_PC fetch.
